// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and hands decode {pc, instr}.
// Optional MISALIGN_TRAP_EN: misaligned redirects halt the unit instead of being truncated.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            halt_req,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    input  logic            id_ready,
    output logic            halted,
    output logic [31:0]     fetch_count,
    output logic            misaligned
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_req_valid;
    logic [31:0]     r_count;

    logic [XLEN-1:0] w_tgt;
    logic            w_active;
    logic            w_run;
    logic            w_misal;
    logic            w_take;
    logic            w_stall;
    logic            w_replay;

    assign w_tgt    = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
    assign w_active = (r_state != S_BOOT);
    assign w_run    = (r_state == S_RUN);

`ifdef MISALIGN_TRAP_EN
    assign w_misal = redirect_valid & w_active & (redirect_pc[1:0] != 2'b00);
`else
    assign w_misal = 1'b0;
`endif

    assign w_take   = redirect_valid & w_active & ~w_misal;
    assign w_stall  = r_req_valid & ~id_ready;
    assign w_replay = w_run & ~redirect_valid & ~halt_req & w_stall;

    // Stalled requests re-present their own address so the memory keeps its data.
    always_comb begin
        imem_addr = r_pc;
        if (!w_active)
            imem_addr = RESET_PC;
        else if (w_take)
            imem_addr = w_tgt;
        else if (w_replay)
            imem_addr = r_req_pc;
    end

    assign if_valid    = r_req_valid & w_run & ~redirect_valid;
    assign if_pc       = r_req_pc;
    assign if_instr    = imem_data;
    assign halted      = (r_state == S_HALT);
    assign fetch_count = r_count;
    assign misaligned  = w_misal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_req_pc    <= '0;
            r_req_valid <= 1'b0;
            r_count     <= 32'd0;
        end else begin
            if (if_valid & id_ready)
                r_count <= r_count + 32'd1;
            if (!w_active) begin
                r_state <= S_RUN;
            end else if (w_misal) begin
                r_state     <= S_HALT;
                r_req_valid <= 1'b0;
            end else if (w_take) begin
                r_state     <= S_RUN;
                r_req_pc    <= w_tgt;
                r_req_valid <= 1'b1;
                r_pc        <= w_tgt + XLEN'(4);
            end else if (w_run) begin
                if (halt_req) begin
                    r_state     <= S_HALT;
                    r_req_valid <= 1'b0;
                end else if (w_stall) begin
                    r_req_valid <= 1'b1;
                end else if (fetch_en) begin
                    r_req_pc    <= r_pc;
                    r_req_valid <= 1'b1;
                    r_pc        <= r_pc + XLEN'(4);
                end else begin
                    r_req_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        halt_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        halted;
    logic [31:0] fetch_count;
    logic        misaligned;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model: mode 0 boot, 1 run, 2 halted
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_show_pc;
    bit          m_live;
    logic [31:0] m_cnt;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .id_ready       (id_ready),
        .halted         (halted),
        .fetch_count    (fetch_count),
        .misaligned     (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered instruction memory: word k holds k
    always @(posedge clk) imem_data <= {2'b00, imem_addr[31:2]};

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_pc      = RESET_PC;
        m_show_pc = 32'd0;
        m_live    = 1'b0;
        m_cnt     = 32'd0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_count", fetch_count, 32'd0);
    endtask

    // Drive one cycle's inputs, check outputs against the model, advance the model.
    task automatic step(bit fe, bit hr, bit rv, logic [31:0] rpc, bit rdy);
        bit          bad;
        bit          jump;
        bit          ev;
        bit          replay;
        logic [31:0] tgt;
        logic [31:0] ea;
        fetch_en       = fe;
        halt_req       = hr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        #1;
        tgt    = {rpc[31:2], 2'b00};
        bad    = TRAP && rv && m_mode != 0 && rpc[1:0] != 2'b00;
        jump   = rv && m_mode != 0 && !bad;
        ev     = m_mode == 1 && m_live && !rv;
        replay = ev && !hr && !rdy;
        if (m_mode == 0)
            ea = RESET_PC;
        else if (jump)
            ea = tgt;
        else if (replay)
            ea = m_show_pc;
        else
            ea = m_pc;
        chk("if_valid", {31'd0, if_valid}, {31'd0, ev});
        chk("if_pc", if_pc, m_show_pc);
        chk("imem_addr", imem_addr, ea);
        chk("halted", {31'd0, halted}, {31'd0, m_mode == 2});
        chk("misaligned", {31'd0, misaligned}, {31'd0, bad});
        chk("fetch_count", fetch_count, m_cnt);
        if (ev)
            chk("if_instr", if_instr, m_show_pc / 4);
        if (ev && rdy)
            m_cnt = m_cnt + 1;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (bad) begin
            m_mode = 2;
            m_live = 1'b0;
        end else if (jump) begin
            m_mode    = 1;
            m_show_pc = tgt;
            m_live    = 1'b1;
            m_pc      = tgt + 4;
        end else if (m_mode == 1) begin
            if (hr) begin
                m_mode = 2;
                m_live = 1'b0;
            end else if (replay) begin
                m_live = 1'b1;
            end else if (fe) begin
                m_show_pc = m_pc;
                m_live    = 1'b1;
                m_pc      = m_pc + 4;
            end else begin
                m_live = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset in the middle of a cycle, released on a later negedge
    task automatic reset_mid();
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        fetch_en       = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;

        step(1, 0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("count_after_3", fetch_count, 32'd3);
        step(1, 0, 1, 32'h40, 1);
        repeat (3) step(1, 0, 0, 0, 1);

        step(1, 1, 0, 0, 1);
        repeat (4) step(1, 1, 0, 0, 1);
        chk("halted_hold", {31'd0, halted}, 32'd1);
        step(1, 1, 1, 32'h10, 1);
        repeat (2) step(1, 0, 0, 0, 1);
        step(1, 0, 1, 32'hFFFF_FFFC, 1);
        step(1, 0, 0, 0, 1);
        chk("wrap_pc", if_pc, 32'd0);
        step(1, 0, 0, 0, 1);

        step(1, 0, 1, 32'h42, 1);
        repeat (2) step(1, 0, 0, 0, 1);
        step(1, 0, 1, 32'h21, 1);
        step(1, 0, 1, 32'h20, 1);
        repeat (2) step(1, 0, 0, 0, 0);
        reset_mid();
        repeat (4) step(1, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0)
                tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            step($urandom_range(0, 9) < 8,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) == 0,
                 tgt,
                 $urandom_range(0, 9) < 7);
            if ($urandom_range(0, 499) == 0)
                reset_mid();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
